operand_fetch: RTL and testbench
================================

# operand_fetch

Decode-side consumer of the register file's two read ports. It drives the read addresses, merges the returned data with in-flight results from MEM and WB, and detects load-use hazards. It also holds the ID/EX pipeline register that feeds the execute stage. It sits between instruction decode and EX in the 5-stage pipeline. It supplies the correct operand whenever the register file has not yet committed a pending write.

## Interface
- `XLEN`, 32: data width.
- `RW`, 5: register index width.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: decode presents an instruction.
- `id_ready` out 1: instruction accepted this cycle.
- `id_rs`, `id_rt`, `id_rd` in RW: register indices.
- `id_uses_rs`, `id_uses_rt` in 1: operand actually read.
- `id_reg_write` in 1: instruction writes a register.
- `id_reg_dst` in 1: destination select. 1 = rt, 0 = rd.
- `id_mem_read` in 1: instruction is a load.
- `id_imm` in XLEN: extended immediate, passed through.
- `rf_rs_addr`, `rf_rt_addr` out RW: register file read addresses, combinational copies of `id_rs`/`id_rt`.
- `rf_rs_data`, `rf_rt_data` in XLEN: register file read data, combinational.
- `mem_reg_write` in 1, `mem_dst` in RW, `mem_result` in XLEN, `mem_is_load` in 1: the instruction currently in MEM.
- `wb_reg_write` in 1, `wb_dst` in RW, `wb_data` in XLEN: the write currently presented to the register file.
- `ex_stall` in 1: EX cannot accept; hold ID/EX.
- `flush` in 1: squash the instruction in decode and the ID/EX contents.
- `ex_valid` out 1.
- `ex_rs_val`, `ex_rt_val` out XLEN.
- `ex_dst` out RW.
- `ex_reg_write` out 1.
- `ex_mem_read` out 1.
- `ex_imm` out XLEN.
- `ex_fwd_rs`, `ex_fwd_rt` out 1: EX must replace the operand with its EX/MEM result.
- `hazard_stalls` out 32: count of load-use stall cycles, saturating.

## Operation
- A register matches a producer only if the index is non-zero, the operand is used, the producer's write flag is set, and the destinations are equal. Register 0 never matches and always reads as 0.
- EX-stage producer is the current ID/EX contents with `ex_valid`=1.
  - Match with `ex_mem_read`=1: load-use stall.
  - Match with `ex_mem_read`=0: register the operand from lower priority sources and set `ex_fwd_*`=1.
- MEM-stage producer:
  - Match with `mem_is_load`=1: load-use stall.
  - Match otherwise: operand = `mem_result`.
- WB match: operand = `wb_data`. This bypass is required because the register file writes on the edge, so a same-cycle read returns the old value.
- Priority: EX flag, then MEM, then WB, then `rf_*_data`.
- `ex_dst` = `id_reg_dst` ? `id_rt` : `id_rd`.
- `id_ready` = !`ex_stall` && !hazard. Hazard is evaluated only when `id_valid`=1.
- ID/EX update on each rising edge, first matching rule applies:
  1. `rst`: all fields cleared.
  2. `flush`: `ex_valid`←0 and all control outputs ←0, even if `ex_stall`=1.
  3. `ex_stall`: hold all fields.
  4. Hazard: insert a bubble. `ex_valid`, `ex_reg_write`, `ex_mem_read`, `ex_fwd_*` ←0.
  5. `id_valid`: capture the new instruction.
  6. Otherwise: insert a bubble.
- `hazard_stalls` increments on every cycle with hazard && !`ex_stall` && !`flush`. It saturates at 0xFFFFFFFF.

## Timing
- Read path (address → data → bypass → ID/EX D input) is combinational. The ID/EX outputs follow one cycle after acceptance.
- Load immediately followed by a dependent instruction costs 2 stall cycles: one with the load in EX, one with the load in MEM. The dependent instruction picks the value up through the WB bypass.
- Values after reset: every output is 0, `hazard_stalls`=0. `rf_*_addr` track the inputs.
- Reset or flush during a stall drops the pending bubble. The next acceptance obeys the normal rules.
- Simultaneous `flush` and `ex_stall`: flush wins.
- Simultaneous hazard and `ex_stall`: hold, with no counter increment.

## Structure
- Shared package `cpu_pkg` holds `XLEN`, `RW`, `REG_ZERO`, and the ID/EX field struct/typedef.
- Sub-module `operand_bypass`: combinational priority mux and hazard detect for one operand. Instantiated twice, once for rs and once for rt.
- Top level holds the ID/EX register, the stall/flush control and the counter.

## Test plan
- WB bypass: `wb_reg_write`=1, `wb_dst`=8, `wb_data`=0x1234, `rf_rs_data`=0, instruction reads rs=8 → `ex_rs_val`=0x1234 next cycle.
- EX forward: ADD writing $9 accepted, then SUB reading rt=9 → second cycle shows `ex_fwd_rt`=1 and `ex_valid`=1, with no stall.
- Load-use: LW $10 followed by ADD reading rs=10 → `id_ready`=0 for 2 cycles, two bubbles with `ex_valid`=0, `hazard_stalls`=2. ADD then captures `wb_data`=0xCAFE.
- Register zero: `mem_dst`=0, `mem_reg_write`=1, `mem_result`=0xFFFF, reading rs=0 → `ex_rs_val`=0, `ex_fwd_rs`=0.
- Flush during `ex_stall`: `flush`=1 and `ex_stall`=1 together → `ex_valid`=0 next cycle.
- Priority: MEM and WB both target $5, with 0xAAAA and 0xBBBB → `ex_rs_val`=0xAAAA. Reset mid-stall → all outputs 0 on the next cycle.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared pipeline constants, the ID/EX payload and the producer match helper.
package cpu_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;

  localparam logic [RW-1:0] REG_ZERO = RW'(0);

  // ID/EX pipeline register contents feeding the execute stage
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [RW-1:0]   dst;
    logic            reg_write;
    logic            mem_read;
    logic [XLEN-1:0] imm;
    logic            fwd_rs;
    logic            fwd_rt;
  } idex_t;

  // A producer matches only a used, non-zero source equal to its written destination
  function automatic logic reg_match(
    input logic [RW-1:0] idx,
    input logic          used,
    input logic          we,
    input logic [RW-1:0] dst
  );
    return (idx != REG_ZERO) && used && we && (idx == dst);
  endfunction

endpackage

// File: rtl/operand_bypass.sv
// Priority bypass mux and load-use hazard detect for a single source operand.
module operand_bypass
  import cpu_pkg::*;
(
  input  logic [RW-1:0]   i_idx,
  input  logic            i_used,
  input  logic            i_ex_valid,
  input  logic            i_ex_reg_write,
  input  logic [RW-1:0]   i_ex_dst,
  input  logic            i_ex_mem_read,
  input  logic            i_mem_reg_write,
  input  logic [RW-1:0]   i_mem_dst,
  input  logic [XLEN-1:0] i_mem_result,
  input  logic            i_mem_is_load,
  input  logic            i_wb_reg_write,
  input  logic [RW-1:0]   i_wb_dst,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic [XLEN-1:0] i_rf_data,
  output logic [XLEN-1:0] o_val_c,
  output logic            o_fwd_c,
  output logic            o_hazard_c
);

  logic w_ex_hit;
  logic w_mem_hit;
  logic w_wb_hit;

  assign w_ex_hit  = i_ex_valid && reg_match(i_idx, i_used, i_ex_reg_write, i_ex_dst);
  assign w_mem_hit = reg_match(i_idx, i_used, i_mem_reg_write, i_mem_dst);
  assign w_wb_hit  = reg_match(i_idx, i_used, i_wb_reg_write, i_wb_dst);

  // Value from the youngest non-EX source; EX results are forwarded later by EX itself
  always_comb begin
    o_val_c    = i_rf_data;
    o_fwd_c    = 1'b0;
    o_hazard_c = 1'b0;
    if (i_idx == REG_ZERO) begin
      o_val_c = XLEN'(0);
    end else if (w_mem_hit) begin
      o_val_c = i_mem_result;
    end else if (w_wb_hit) begin
      o_val_c = i_wb_data;
    end
    if (w_ex_hit) begin
      if (i_ex_mem_read) begin
        o_hazard_c = 1'b1;
      end else begin
        o_fwd_c = 1'b1;
      end
    end else if (w_mem_hit && i_mem_is_load) begin
      o_hazard_c = 1'b1;
    end
  end

endmodule

// File: rtl/operand_fetch.sv
// Register file read, operand bypass, load-use stall and the ID/EX register.
module operand_fetch
  import cpu_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_id_valid,
  output logic            o_id_ready,
  input  logic [RW-1:0]   i_id_rs,
  input  logic [RW-1:0]   i_id_rt,
  input  logic [RW-1:0]   i_id_rd,
  input  logic            i_id_uses_rs,
  input  logic            i_id_uses_rt,
  input  logic            i_id_reg_write,
  input  logic            i_id_reg_dst,
  input  logic            i_id_mem_read,
  input  logic [XLEN-1:0] i_id_imm,
  output logic [RW-1:0]   o_rf_rs_addr,
  output logic [RW-1:0]   o_rf_rt_addr,
  input  logic [XLEN-1:0] i_rf_rs_data,
  input  logic [XLEN-1:0] i_rf_rt_data,
  input  logic            i_mem_reg_write,
  input  logic [RW-1:0]   i_mem_dst,
  input  logic [XLEN-1:0] i_mem_result,
  input  logic            i_mem_is_load,
  input  logic            i_wb_reg_write,
  input  logic [RW-1:0]   i_wb_dst,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_ex_stall,
  input  logic            i_flush,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_rs_val,
  output logic [XLEN-1:0] o_ex_rt_val,
  output logic [RW-1:0]   o_ex_dst,
  output logic            o_ex_reg_write,
  output logic            o_ex_mem_read,
  output logic [XLEN-1:0] o_ex_imm,
  output logic            o_ex_fwd_rs,
  output logic            o_ex_fwd_rt,
  output logic [31:0]     o_hazard_stalls
);

  idex_t           r_idex;
  idex_t           w_idex_d;
  logic [31:0]     r_hazard_stalls;
  logic [XLEN-1:0] w_rs_val;
  logic [XLEN-1:0] w_rt_val;
  logic            w_rs_fwd;
  logic            w_rt_fwd;
  logic            w_rs_haz;
  logic            w_rt_haz;
  logic            w_hazard;

  assign o_rf_rs_addr = i_id_rs;
  assign o_rf_rt_addr = i_id_rt;

  operand_bypass u_rs_bypass (
    .i_idx           (i_id_rs),
    .i_used          (i_id_uses_rs),
    .i_ex_valid      (r_idex.valid),
    .i_ex_reg_write  (r_idex.reg_write),
    .i_ex_dst        (r_idex.dst),
    .i_ex_mem_read   (r_idex.mem_read),
    .i_mem_reg_write (i_mem_reg_write),
    .i_mem_dst       (i_mem_dst),
    .i_mem_result    (i_mem_result),
    .i_mem_is_load   (i_mem_is_load),
    .i_wb_reg_write  (i_wb_reg_write),
    .i_wb_dst        (i_wb_dst),
    .i_wb_data       (i_wb_data),
    .i_rf_data       (i_rf_rs_data),
    .o_val_c         (w_rs_val),
    .o_fwd_c         (w_rs_fwd),
    .o_hazard_c      (w_rs_haz)
  );

  operand_bypass u_rt_bypass (
    .i_idx           (i_id_rt),
    .i_used          (i_id_uses_rt),
    .i_ex_valid      (r_idex.valid),
    .i_ex_reg_write  (r_idex.reg_write),
    .i_ex_dst        (r_idex.dst),
    .i_ex_mem_read   (r_idex.mem_read),
    .i_mem_reg_write (i_mem_reg_write),
    .i_mem_dst       (i_mem_dst),
    .i_mem_result    (i_mem_result),
    .i_mem_is_load   (i_mem_is_load),
    .i_wb_reg_write  (i_wb_reg_write),
    .i_wb_dst        (i_wb_dst),
    .i_wb_data       (i_wb_data),
    .i_rf_data       (i_rf_rt_data),
    .o_val_c         (w_rt_val),
    .o_fwd_c         (w_rt_fwd),
    .o_hazard_c      (w_rt_haz)
  );

  assign w_hazard   = i_id_valid && (w_rs_haz || w_rt_haz);
  assign o_id_ready = !i_ex_stall && !w_hazard;

  // ID/EX next state: flush beats stall, stall holds, hazard or idle decode bubbles
  always_comb begin
    w_idex_d = r_idex;
    if (i_flush) begin
      w_idex_d.valid     = 1'b0;
      w_idex_d.reg_write = 1'b0;
      w_idex_d.mem_read  = 1'b0;
      w_idex_d.fwd_rs    = 1'b0;
      w_idex_d.fwd_rt    = 1'b0;
    end else if (!i_ex_stall) begin
      if (w_hazard || !i_id_valid) begin
        w_idex_d.valid     = 1'b0;
        w_idex_d.reg_write = 1'b0;
        w_idex_d.mem_read  = 1'b0;
        w_idex_d.fwd_rs    = 1'b0;
        w_idex_d.fwd_rt    = 1'b0;
      end else begin
        w_idex_d.valid     = 1'b1;
        w_idex_d.rs_val    = w_rs_val;
        w_idex_d.rt_val    = w_rt_val;
        w_idex_d.dst       = i_id_reg_dst ? i_id_rt : i_id_rd;
        w_idex_d.reg_write = i_id_reg_write;
        w_idex_d.mem_read  = i_id_mem_read;
        w_idex_d.imm       = i_id_imm;
        w_idex_d.fwd_rs    = w_rs_fwd;
        w_idex_d.fwd_rt    = w_rt_fwd;
      end
    end
  end

  // ID/EX pipeline register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idex <= '0;
    end else begin
      r_idex <= w_idex_d;
    end
  end

  // Saturating count of cycles lost to load-use stalls
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hazard_stalls <= 32'd0;
    end else if (w_hazard && !i_ex_stall && !i_flush && (r_hazard_stalls != 32'hFFFF_FFFF)) begin
      r_hazard_stalls <= r_hazard_stalls + 32'd1;
    end
  end

  assign o_ex_valid      = r_idex.valid;
  assign o_ex_rs_val     = r_idex.rs_val;
  assign o_ex_rt_val     = r_idex.rt_val;
  assign o_ex_dst        = r_idex.dst;
  assign o_ex_reg_write  = r_idex.reg_write;
  assign o_ex_mem_read   = r_idex.mem_read;
  assign o_ex_imm        = r_idex.imm;
  assign o_ex_fwd_rs     = r_idex.fwd_rs;
  assign o_ex_fwd_rt     = r_idex.fwd_rt;
  assign o_hazard_stalls = r_hazard_stalls;

endmodule

// File: tb/tb_operand_fetch.sv
// Directed checks of operand bypass, forwarding flags, load-use stalls and flush.
module tb_operand_fetch;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_uses_rs, id_uses_rt, id_reg_write, id_reg_dst, id_mem_read;
  logic [31:0] id_imm;
  logic [4:0]  rf_rs_addr, rf_rt_addr;
  logic [31:0] rf_rs_data, rf_rt_data;
  logic        mem_reg_write, mem_is_load;
  logic [4:0]  mem_dst;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_dst;
  logic [31:0] wb_data;
  logic        ex_stall, flush;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_fwd_rs, ex_fwd_rt;
  logic [31:0] ex_rs_val, ex_rt_val, ex_imm, hazard_stalls;
  logic [4:0]  ex_dst;

  int total = 0;
  int bad   = 0;

  operand_fetch dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_id_valid      (id_valid),
    .o_id_ready      (id_ready),
    .i_id_rs         (id_rs),
    .i_id_rt         (id_rt),
    .i_id_rd         (id_rd),
    .i_id_uses_rs    (id_uses_rs),
    .i_id_uses_rt    (id_uses_rt),
    .i_id_reg_write  (id_reg_write),
    .i_id_reg_dst    (id_reg_dst),
    .i_id_mem_read   (id_mem_read),
    .i_id_imm        (id_imm),
    .o_rf_rs_addr    (rf_rs_addr),
    .o_rf_rt_addr    (rf_rt_addr),
    .i_rf_rs_data    (rf_rs_data),
    .i_rf_rt_data    (rf_rt_data),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_dst       (mem_dst),
    .i_mem_result    (mem_result),
    .i_mem_is_load   (mem_is_load),
    .i_wb_reg_write  (wb_reg_write),
    .i_wb_dst        (wb_dst),
    .i_wb_data       (wb_data),
    .i_ex_stall      (ex_stall),
    .i_flush         (flush),
    .o_ex_valid      (ex_valid),
    .o_ex_rs_val     (ex_rs_val),
    .o_ex_rt_val     (ex_rt_val),
    .o_ex_dst        (ex_dst),
    .o_ex_reg_write  (ex_reg_write),
    .o_ex_mem_read   (ex_mem_read),
    .o_ex_imm        (ex_imm),
    .o_ex_fwd_rs     (ex_fwd_rs),
    .o_ex_fwd_rt     (ex_fwd_rt),
    .o_hazard_stalls (hazard_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle past the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic urs, input logic urt, input logic rw, input logic rdst,
                       input logic mr, input logic [31:0] imm);
    id_valid     = 1'b1;
    id_rs        = rs;
    id_rt        = rt;
    id_rd        = rd;
    id_uses_rs   = urs;
    id_uses_rt   = urt;
    id_reg_write = rw;
    id_reg_dst   = rdst;
    id_mem_read  = mr;
    id_imm       = imm;
  endtask

  task automatic clear_producers();
    mem_reg_write = 1'b0;
    mem_dst       = 5'd0;
    mem_result    = 32'd0;
    mem_is_load   = 1'b0;
    wb_reg_write  = 1'b0;
    wb_dst        = 5'd0;
    wb_data       = 32'd0;
  endtask

  initial begin
    rst = 1'b1;
    ex_stall = 1'b0;
    flush = 1'b0;
    rf_rs_data = 32'd0;
    rf_rt_data = 32'd0;
    clear_producers();
    issue(5'd3, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    id_valid = 1'b0;
    tick();
    tick();

    // reset state
    check_eq("rst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("rst_ex_rs_val", ex_rs_val, 32'd0);
    check_eq("rst_ex_dst", 32'(ex_dst), 32'd0);
    check_eq("rst_hazard_stalls", hazard_stalls, 32'd0);
    check_eq("rst_rf_rs_addr", 32'(rf_rs_addr), 32'd3);
    rst = 1'b0;

    // WB bypass
    wb_reg_write = 1'b1; wb_dst = 5'd8; wb_data = 32'h1234;
    rf_rs_data = 32'd0;
    issue(5'd8, 5'd0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10);
    #1;
    check_eq("wb_id_ready", 32'(id_ready), 32'd1);
    tick();
    check_eq("wb_ex_rs_val", ex_rs_val, 32'h1234);
    check_eq("wb_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("wb_ex_dst", 32'(ex_dst), 32'd1);
    check_eq("wb_ex_fwd_rs", 32'(ex_fwd_rs), 32'd0);

    // EX forward: ADD $9 then SUB reading rt=9
    clear_producers();
    issue(5'd0, 5'd0, 5'd9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h20);
    tick();
    check_eq("add_ex_dst", 32'(ex_dst), 32'd9);
    rf_rt_data = 32'h77;
    issue(5'd0, 5'd9, 5'd11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h30);
    #1;
    check_eq("fwd_id_ready", 32'(id_ready), 32'd1);
    tick();
    check_eq("fwd_ex_fwd_rt", 32'(ex_fwd_rt), 32'd1);
    check_eq("fwd_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("fwd_ex_fwd_rs", 32'(ex_fwd_rs), 32'd0);
    check_eq("fwd_ex_rt_val", ex_rt_val, 32'h77);

    // Load-use: LW $10 then ADD reading rs=10
    issue(5'd2, 5'd10, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h4);
    tick();
    check_eq("lw_ex_mem_read", 32'(ex_mem_read), 32'd1);
    check_eq("lw_ex_dst", 32'(ex_dst), 32'd10);
    issue(5'd10, 5'd0, 5'd12, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h50);
    #1;
    check_eq("lu_ready_c1", 32'(id_ready), 32'd0);
    tick();
    check_eq("lu_bubble1", 32'(ex_valid), 32'd0);
    mem_reg_write = 1'b1; mem_dst = 5'd10; mem_is_load = 1'b1; mem_result = 32'hDEAD;
    #1;
    check_eq("lu_ready_c2", 32'(id_ready), 32'd0);
    tick();
    check_eq("lu_bubble2", 32'(ex_valid), 32'd0);
    check_eq("lu_stalls", hazard_stalls, 32'd2);
    clear_producers();
    wb_reg_write = 1'b1; wb_dst = 5'd10; wb_data = 32'hCAFE;
    rf_rs_data = 32'd0;
    #1;
    check_eq("lu_ready_c3", 32'(id_ready), 32'd1);
    tick();
    check_eq("lu_ex_rs_val", ex_rs_val, 32'hCAFE);
    check_eq("lu_ex_valid", 32'(ex_valid), 32'd1);
    check_eq("lu_stalls_after", hazard_stalls, 32'd2);

    // Register zero never matches
    clear_producers();
    mem_reg_write = 1'b1; mem_dst = 5'd0; mem_result = 32'hFFFF;
    rf_rs_data = 32'h55;
    issue(5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h60);
    tick();
    check_eq("r0_ex_rs_val", ex_rs_val, 32'd0);
    check_eq("r0_ex_fwd_rs", 32'(ex_fwd_rs), 32'd0);

    // MEM beats WB; unused rt ignores producers
    clear_producers();
    mem_reg_write = 1'b1; mem_dst = 5'd5; mem_result = 32'hAAAA;
    wb_reg_write = 1'b1; wb_dst = 5'd5; wb_data = 32'hBBBB;
    rf_rt_data = 32'h66;
    issue(5'd5, 5'd5, 5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h70);
    tick();
    check_eq("prio_ex_rs_val", ex_rs_val, 32'hAAAA);
    check_eq("prio_ex_rt_val", ex_rt_val, 32'h66);
    check_eq("prio_ex_imm", ex_imm, 32'h70);

    // Flush together with ex_stall
    clear_producers();
    ex_stall = 1'b1; flush = 1'b1;
    issue(5'd1, 5'd2, 5'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h80);
    tick();
    check_eq("flush_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("flush_ex_reg_write", 32'(ex_reg_write), 32'd0);
    flush = 1'b0;
    #1;
    check_eq("stall_id_ready", 32'(id_ready), 32'd0);
    tick();
    check_eq("stall_hold_valid", 32'(ex_valid), 32'd0);

    // Hazard under ex_stall holds without counting, then reset mid-stall
    ex_stall = 1'b0;
    issue(5'd0, 5'd10, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44);
    tick();
    issue(5'd10, 5'd0, 5'd16, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h99);
    ex_stall = 1'b1;
    tick();
    check_eq("hs_stalls_held", hazard_stalls, 32'd2);
    check_eq("hs_ex_mem_read", 32'(ex_mem_read), 32'd1);
    ex_stall = 1'b0;
    #1;
    check_eq("hs_id_ready", 32'(id_ready), 32'd0);
    tick();
    check_eq("hs_stalls_inc", hazard_stalls, 32'd3);
    rst = 1'b1;
    tick();
    check_eq("mrst_ex_valid", 32'(ex_valid), 32'd0);
    check_eq("mrst_ex_dst", 32'(ex_dst), 32'd0);
    check_eq("mrst_ex_imm", ex_imm, 32'd0);
    check_eq("mrst_ex_rs_val", ex_rs_val, 32'd0);
    check_eq("mrst_ex_mem_read", 32'(ex_mem_read), 32'd0);
    check_eq("mrst_stalls", hazard_stalls, 32'd0);
    check_eq("mrst_rf_rs_addr", 32'(rf_rs_addr), 32'd10);
    rst = 1'b0;
    id_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
